// File: rtl/imm_gen_pipe_if.sv
// Handshake and result bundle for imm_gen_pipe: instruction input side, decoded
// immediate output side, plus status (occupancy, illegal counter).
interface imm_gen_pipe_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
);
  logic [31:0]      instruction;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  immediate;
  logic [2:0]       imm_type;
  logic             illegal;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] illegal_count;

  modport master (
    output instruction, in_valid, flush, out_ready,
    input  in_ready, out_valid, immediate, imm_type, illegal, occupancy, illegal_count
  );

  modport slave (
    input  instruction, in_valid, flush, out_ready,
    output in_ready, out_valid, immediate, imm_type, illegal, occupancy, illegal_count
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with a two-entry (output + skid) elastic buffer.
// Decode happens before storage; in_ready depends only on registered state.
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  imm_gen_pipe_if.slave bus
);

  localparam logic [2:0] TYPE_NONE    = 3'd0;
  localparam logic [2:0] TYPE_I       = 3'd1;
  localparam logic [2:0] TYPE_S       = 3'd2;
  localparam logic [2:0] TYPE_B       = 3'd3;
  localparam logic [2:0] TYPE_U       = 3'd4;
  localparam logic [2:0] TYPE_J       = 3'd5;
  localparam logic [2:0] TYPE_ILLEGAL = 3'd7;

  logic [31:0]        inst;
  logic [6:0]         opcode;
  logic               sign;
  logic signed [31:0] raw_imm;
  logic [XLEN-1:0]    dec_imm;
  logic [2:0]         dec_type;
  logic               dec_illegal;

  logic               out_valid_q;
  logic [XLEN-1:0]    out_imm_q;
  logic [2:0]         out_type_q;
  logic               out_illegal_q;

  logic               skid_valid_q;
  logic [XLEN-1:0]    skid_imm_q;
  logic [2:0]         skid_type_q;
  logic               skid_illegal_q;

  logic [CNT_W-1:0]   illegal_count_q;

  logic               accept;
  logic               consume;
  logic               in_ready;

  assign inst    = bus.instruction;
  assign opcode  = inst[6:0];
  assign sign    = inst[31];

  assign in_ready = !skid_valid_q;
  assign accept   = bus.in_valid && in_ready && !bus.flush;
  assign consume  = out_valid_q && bus.out_ready;

  // Build the 32-bit sign-extended immediate first, then widen to XLEN.
  always_comb begin
    raw_imm     = '0;
    dec_type    = TYPE_ILLEGAL;
    dec_illegal = 1'b1;
    unique case (opcode)
      7'b0000011, 7'b0010011, 7'b1100111: begin
        raw_imm     = {{20{sign}}, inst[31:20]};
        dec_type    = TYPE_I;
        dec_illegal = 1'b0;
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          raw_imm     = {{20{sign}}, inst[31:20]};
          dec_type    = TYPE_I;
          dec_illegal = 1'b0;
        end
      end
      7'b0100011: begin
        raw_imm     = {{20{sign}}, inst[31:25], inst[11:7]};
        dec_type    = TYPE_S;
        dec_illegal = 1'b0;
      end
      7'b1100011: begin
        raw_imm     = {{19{sign}}, sign, inst[7], inst[30:25], inst[11:8], 1'b0};
        dec_type    = TYPE_B;
        dec_illegal = 1'b0;
      end
      7'b0110111, 7'b0010111: begin
        raw_imm     = {inst[31:12], 12'b0};
        dec_type    = TYPE_U;
        dec_illegal = 1'b0;
      end
      7'b1101111: begin
        raw_imm     = {{11{sign}}, sign, inst[19:12], inst[20], inst[30:21], 1'b0};
        dec_type    = TYPE_J;
        dec_illegal = 1'b0;
      end
      7'b0110011, 7'b0111011: begin
        dec_type    = TYPE_NONE;
        dec_illegal = 1'b0;
      end
      default: begin
        raw_imm     = '0;
        dec_type    = TYPE_ILLEGAL;
        dec_illegal = 1'b1;
      end
    endcase
  end

  assign dec_imm = XLEN'(raw_imm);

  // Output slot refills from the skid first so FIFO order holds; a new entry
  // only lands in the skid when the output is full and stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q    <= 1'b0;
      out_imm_q      <= '0;
      out_type_q     <= TYPE_NONE;
      out_illegal_q  <= 1'b0;
      skid_valid_q   <= 1'b0;
      skid_imm_q     <= '0;
      skid_type_q    <= TYPE_NONE;
      skid_illegal_q <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      if (!out_valid_q || consume) begin
        if (skid_valid_q) begin
          out_valid_q   <= 1'b1;
          out_imm_q     <= skid_imm_q;
          out_type_q    <= skid_type_q;
          out_illegal_q <= skid_illegal_q;
          skid_valid_q  <= 1'b0;
        end else if (accept) begin
          out_valid_q   <= 1'b1;
          out_imm_q     <= dec_imm;
          out_type_q    <= dec_type;
          out_illegal_q <= dec_illegal;
        end else begin
          out_valid_q   <= 1'b0;
        end
      end else if (accept) begin
        skid_valid_q   <= 1'b1;
        skid_imm_q     <= dec_imm;
        skid_type_q    <= dec_type;
        skid_illegal_q <= dec_illegal;
      end
    end
  end

  // Saturating count of accepted illegal instructions; flush does not clear it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_count_q <= '0;
    end else if (accept && dec_illegal && (illegal_count_q != {CNT_W{1'b1}})) begin
      illegal_count_q <= illegal_count_q + 1'b1;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid_q;
  assign bus.immediate     = out_imm_q;
  assign bus.imm_type      = out_type_q;
  assign bus.illegal       = out_illegal_q;
  assign bus.occupancy     = 2'(out_valid_q) + 2'(skid_valid_q);
  assign bus.illegal_count = illegal_count_q;

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 64, immediate width; legal values 32 and 64.
REQ-002 Parameter CNT_W, default 16, width of the illegal-instruction counter.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 instruction  input  32  RISC-V instruction word to decode.
REQ-006 in_valid  input  1  instruction is valid this cycle.
REQ-007 in_ready  output  1  block can accept an instruction this cycle.
REQ-008 flush  input  1  synchronous pipeline flush; discards all held entries.
REQ-009 out_valid  output  1  immediate/imm_type/illegal are valid.
REQ-010 out_ready  input  1  downstream consumes the output this cycle.
REQ-011 immediate  output  XLEN  sign-extended immediate.
REQ-012 imm_type  output  3  0=none(R), 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
REQ-013 illegal  output  1  output entry carries an unsupported opcode.
REQ-014 occupancy  output  2  entries held (0..2).
REQ-015 illegal_count  output  CNT_W  accepted illegal instructions, saturating.

Function
REQ-016 Accept = in_valid && in_ready && !flush; consume = out_valid && out_ready.
REQ-017 Storage: one output register plus one skid register; FIFO order preserved.
REQ-018 Latency: accepted in cycle N into an empty block -> out_valid in N+1.
REQ-019 in_ready = !skid_full, driven from registered state only (no combinational path from out_ready).
REQ-020 Accept with output empty, or output consumed same cycle -> entry written to output register.
REQ-021 Accept with output full and not consumed -> entry written to skid; in_ready low from next cycle.
REQ-022 Consume with skid full -> skid moves to output in the same edge; in_ready high next cycle.
REQ-023 Decode by opcode[6:0]: 0000011, 0010011, 1100111 -> I; 0011011 -> I if XLEN=64, else illegal; 0100011 -> S; 1100011 -> B; 0110111, 0010111 -> U; 1101111 -> J; 0110011, 0111011 -> none.
REQ-024 I = inst[31:20]; S = {inst[31:25],inst[11:7]}; B = {inst[31],inst[7],inst[30:25],inst[11:8],0}; U = {inst[31:12],12'b0}; J = {inst[31],inst[19:12],inst[20],inst[30:21],0}.
REQ-025 All immediates are sign-extended from inst[31] to XLEN; none/illegal give immediate 0.
REQ-026 Decode is done before storage; the stored entry holds immediate, imm_type and illegal.
REQ-027 Any other opcode -> illegal=1, imm_type=7, immediate=0; the entry still flows through as a normal entry.
REQ-028 illegal_count increments by 1 on each accepted illegal instruction, holds at all-ones, and is not cleared by flush.
REQ-029 flush has priority over everything else: both entries are invalidated next cycle, occupancy=0, in_ready=1, and any same-cycle input is dropped and not counted.
REQ-030 Simultaneous accept and consume with occupancy 1 -> occupancy stays 1; the new entry takes the output.
REQ-031 occupancy is exact at all times; it never exceeds 2 and never underflows.

Reset
REQ-032 Reset asserted -> immediately: out_valid=0, immediate=0, imm_type=0, illegal=0, occupancy=0, illegal_count=0, in_ready=1.
REQ-033 Reset mid-operation discards both entries; no entry is emitted after deassertion.
REQ-034 First accept is possible on the first posedge after reset deassertion.

Verification
REQ-035 XLEN=64, inst 0x00100003, out_ready=1 -> next cycle out_valid=1, immediate=1, imm_type=1.
REQ-036 inst 0xFE000FE3 (B, -2) -> immediate=0xFFFFFFFFFFFFFFFE, imm_type=3; inst 0x80000037 -> 0xFFFFFFFF80000000, imm_type=4.
REQ-037 out_ready=0, three back-to-back accepts of 0x00100003, 0x00200003, 0x00300003 -> occupancy 2, in_ready=0, third held; then out_ready=1 -> outputs 1, 2, 3 in order.
REQ-038 Occupancy 2 plus flush with in_valid=1 -> next cycle out_valid=0, occupancy=0, in_ready=1, illegal_count unchanged.
REQ-039 inst 0x0000007F -> illegal=1, imm_type=7, immediate=0, illegal_count+1; XLEN=32 with 0x0000001B -> illegal; CNT_W=2 with 5 illegals -> count=3.
REQ-040 Reset pulse between clock edges at occupancy 2 -> outputs at reset values immediately, no stale output after release.
